// File: rtl/gc_pkg.sv
// Shared types and constants for the GameCube poll scheduler: FSM states,
// button indices, response bit positions and neutral analog values.
package gc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_UPDATE
    } gc_state_e;

    localparam int RD_W    = 64;
    localparam int NUM_BTN = 12;

    // Index of each button in the held/pressed/released vectors.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_X      = 2;
    localparam int BTN_Y      = 3;
    localparam int BTN_START  = 4;
    localparam int BTN_L      = 5;
    localparam int BTN_R      = 6;
    localparam int BTN_Z      = 7;
    localparam int BTN_DUP    = 8;
    localparam int BTN_DDOWN  = 9;
    localparam int BTN_DRIGHT = 10;
    localparam int BTN_DLEFT  = 11;

    // Bit positions in the 64-bit response (bit 63 arrives first).
    localparam int POS_HDR_HI    = 63;
    localparam int POS_HDR_LO    = 61;
    localparam int POS_START     = 60;
    localparam int POS_Y         = 59;
    localparam int POS_X         = 58;
    localparam int POS_B         = 57;
    localparam int POS_A         = 56;
    localparam int POS_VALID     = 55;
    localparam int POS_L         = 54;
    localparam int POS_R         = 53;
    localparam int POS_Z         = 52;
    localparam int POS_DUP       = 51;
    localparam int POS_DDOWN     = 50;
    localparam int POS_DRIGHT    = 49;
    localparam int POS_DLEFT     = 48;
    localparam int POS_ANALOG_HI = 47;

    localparam logic [7:0] STICK_NEUTRAL = 8'h80;
    localparam logic [7:0] TRIG_NEUTRAL  = 8'h00;

    // Field order matches the response: joy_x lands on [47:40].
    typedef struct packed {
        logic [7:0] joy_x;
        logic [7:0] joy_y;
        logic [7:0] c_x;
        logic [7:0] c_y;
        logic [7:0] l_trig;
        logic [7:0] r_trig;
    } gc_analog_t;

    localparam gc_analog_t ANALOG_NEUTRAL = '{
        joy_x:  STICK_NEUTRAL,
        joy_y:  STICK_NEUTRAL,
        c_x:    STICK_NEUTRAL,
        c_y:    STICK_NEUTRAL,
        l_trig: TRIG_NEUTRAL,
        r_trig: TRIG_NEUTRAL
    };

endpackage

// File: rtl/gc_poll_scheduler_if.sv
// Handshake between the poll scheduler (master) and the single-wire reader (slave).
interface gc_poll_scheduler_if;
    import gc_pkg::*;

    logic            rd_start;
    logic            rd_abort;
    logic            rd_done;
    logic            rd_err;
    logic [RD_W-1:0] rd_data;

    modport master (
        output rd_start,
        output rd_abort,
        input  rd_done,
        input  rd_err,
        input  rd_data
    );

    modport slave (
        input  rd_start,
        input  rd_abort,
        output rd_done,
        output rd_err,
        output rd_data
    );

endinterface

// File: rtl/gc_edge_detect.sv
// Held-button register with one-cycle pressed/released pulses. A clear drops
// every held button, which shows up as a released pulse for each of them.
module gc_edge_detect
    import gc_pkg::*;
#(
    parameter int W = NUM_BTN
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] btn_o,
    output logic [W-1:0] pressed_o,
    output logic [W-1:0] released_o
);

    logic [W-1:0] btn_q;
    logic [W-1:0] pressed_q;
    logic [W-1:0] released_q;

    // Update held state and emit edge pulses; clear takes priority over load.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            btn_q      <= '0;
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            pressed_q  <= '0;
            released_q <= '0;
            if (clr_i) begin
                btn_q      <= '0;
                released_q <= btn_q;
            end else if (load_i) begin
                btn_q      <= btn_i;
                pressed_q  <= btn_i & ~btn_q;
                released_q <= ~btn_i & btn_q;
            end
        end
    end

    assign btn_o      = btn_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;

endmodule

// File: rtl/gc_poll_scheduler.sv
// GameCube poll scheduler: periodic poll requests, WAIT timeout with abort,
// response validation, snapshot latching and debounced connected flag.
module gc_poll_scheduler
    import gc_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int POLL_HZ     = 120,
    parameter int TIMEOUT_CYC = 50_000,
    parameter int MAX_FAIL    = 3
) (
    input  logic                clk,
    input  logic                reset,
    gc_poll_scheduler_if.master rd,
    output logic [NUM_BTN-1:0]  buttons,
    output logic [7:0]          joy_x,
    output logic [7:0]          joy_y,
    output logic [7:0]          c_x,
    output logic [7:0]          c_y,
    output logic [7:0]          l_trig,
    output logic [7:0]          r_trig,
    output logic [NUM_BTN-1:0]  pressed,
    output logic [NUM_BTN-1:0]  released,
    output logic                frame_valid,
    output logic                connected
);

    localparam int POLL_DIV = CLK_HZ / POLL_HZ;
    localparam int DIV_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int FC_W     = $clog2(MAX_FAIL + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(POLL_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(MAX_FAIL);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(MAX_FAIL - 1);

    gc_state_e          state_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               pending_q, pending_d;
    logic [TO_W-1:0]    to_cnt_q;
    logic [RD_W-1:0]    data_q;
    logic               err_q;
    logic [FC_W-1:0]    fail_cnt_q;
    logic               connected_q;
    logic               frame_valid_q;
    logic               rd_start_q;
    logic               rd_abort_q;
    gc_analog_t         analog_q;
    gc_analog_t         analog_new;
    logic [NUM_BTN-1:0] btn_new;
    logic               wrap;
    logic               frame_ok;
    logic               fail_last;
    logic               snap_load;
    logic               snap_clr;

    // Free-running poll divider; a tick arriving while one is pending is dropped.
    always_comb begin
        wrap      = (div_q == DIV_LAST);
        div_d     = wrap ? '0 : div_q + 1'b1;
        pending_d = pending_q;
        if (state_q == ST_IDLE && pending_q) begin
            pending_d = 1'b0;
        end else if (wrap) begin
            pending_d = 1'b1;
        end
    end

    // Divider and pending registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pending_q <= pending_d;
        end
    end

    // Decode the captured response and decide how UPDATE treats it.
    always_comb begin
        btn_new             = '0;
        btn_new[BTN_A]      = data_q[POS_A];
        btn_new[BTN_B]      = data_q[POS_B];
        btn_new[BTN_X]      = data_q[POS_X];
        btn_new[BTN_Y]      = data_q[POS_Y];
        btn_new[BTN_START]  = data_q[POS_START];
        btn_new[BTN_L]      = data_q[POS_L];
        btn_new[BTN_R]      = data_q[POS_R];
        btn_new[BTN_Z]      = data_q[POS_Z];
        btn_new[BTN_DUP]    = data_q[POS_DUP];
        btn_new[BTN_DDOWN]  = data_q[POS_DDOWN];
        btn_new[BTN_DRIGHT] = data_q[POS_DRIGHT];
        btn_new[BTN_DLEFT]  = data_q[POS_DLEFT];
        analog_new = gc_analog_t'(data_q[POS_ANALOG_HI:0]);
        frame_ok   = !err_q && (data_q[POS_HDR_HI:POS_HDR_LO] == 3'b000)
                     && data_q[POS_VALID];
        fail_last  = (fail_cnt_q == FC_LAST);
        snap_load  = (state_q == ST_UPDATE) && frame_ok;
        snap_clr   = (state_q == ST_UPDATE) && !frame_ok && fail_last;
    end

    gc_edge_detect #(.W(NUM_BTN)) u_edge (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (snap_load),
        .clr_i      (snap_clr),
        .btn_i      (btn_new),
        .btn_o      (buttons),
        .pressed_o  (pressed),
        .released_o (released)
    );

    // Poll FSM with registered handshake, snapshot and connection outputs.
    // A timeout is folded into UPDATE as an errored frame so both failure
    // kinds share one debounce path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rd_start_q    <= 1'b0;
            rd_abort_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            to_cnt_q      <= '0;
            data_q        <= '0;
            err_q         <= 1'b0;
            fail_cnt_q    <= '0;
            connected_q   <= 1'b0;
            analog_q      <= ANALOG_NEUTRAL;
        end else begin
            rd_start_q    <= 1'b0;
            rd_abort_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        rd_start_q <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    to_cnt_q <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rd.rd_done) begin
                        data_q  <= rd.rd_data;
                        err_q   <= rd.rd_err;
                        state_q <= ST_UPDATE;
                    end else if (to_cnt_q == TO_LAST) begin
                        rd_abort_q <= 1'b1;
                        err_q      <= 1'b1;
                        state_q    <= ST_UPDATE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state_q <= ST_IDLE;
                    if (frame_ok) begin
                        analog_q      <= analog_new;
                        frame_valid_q <= 1'b1;
                        fail_cnt_q    <= '0;
                        connected_q   <= 1'b1;
                    end else if (fail_cnt_q < FC_MAX) begin
                        fail_cnt_q <= fail_cnt_q + 1'b1;
                        if (fail_last) begin
                            connected_q <= 1'b0;
                            analog_q    <= ANALOG_NEUTRAL;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd.rd_start  = rd_start_q;
    assign rd.rd_abort  = rd_abort_q;
    assign frame_valid  = frame_valid_q;
    assign connected    = connected_q;
    assign joy_x        = analog_q.joy_x;
    assign joy_y        = analog_q.joy_y;
    assign c_x          = analog_q.c_x;
    assign c_y          = analog_q.c_y;
    assign l_trig       = analog_q.l_trig;
    assign r_trig       = analog_q.r_trig;

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// Directed bench for gc_poll_scheduler: a table of reader responses with
// hand-computed snapshots, plus pending-drop and mid-transaction reset sequences.
module tb_gc_poll_scheduler;
    import gc_pkg::*;

    localparam int CLK_HZ      = 10_000;
    localparam int POLL_HZ     = 100;
    localparam int POLL_DIV    = CLK_HZ / POLL_HZ;
    localparam int TIMEOUT_CYC = 400;
    localparam int MAX_FAIL    = 3;
    localparam int NVEC        = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] buttons, pressed, released;
    logic [7:0]  joy_x, joy_y, c_x, c_y, l_trig, r_trig;
    logic        frame_valid, connected;

    gc_poll_scheduler_if rd_if();

    gc_poll_scheduler #(
        .CLK_HZ(CLK_HZ), .POLL_HZ(POLL_HZ),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_FAIL(MAX_FAIL)
    ) dut (
        .clk(clk), .reset(reset), .rd(rd_if),
        .buttons(buttons), .joy_x(joy_x), .joy_y(joy_y), .c_x(c_x), .c_y(c_y),
        .l_trig(l_trig), .r_trig(r_trig), .pressed(pressed), .released(released),
        .frame_valid(frame_valid), .connected(connected)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;   // cycles from rd_start to rd_done; -1 = never answer
        logic        err;
        logic [63:0] data;
        logic [11:0] e_btn;
        logic [11:0] e_pr;
        logic [11:0] e_rl;
        logic        e_fv;
        logic        e_conn;
        logic [47:0] e_an;  // {joy_x, joy_y, c_x, c_y, l_trig, r_trig}
    } vec_t;

    vec_t vecs[NVEC];
    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_abort = 0;
    int n_b2b = 0;
    logic prev_start = 1'b0, prev_abort = 1'b0, prev_fv = 1'b0;

    // Pulse monitor, sampled well after the active edge.
    always @(posedge clk) begin
        #2;
        if (rd_if.rd_start) n_start++;
        if (rd_if.rd_abort) n_abort++;
        if ((rd_if.rd_start && prev_start) || (rd_if.rd_abort && prev_abort)
            || (frame_valid && prev_fv)) n_b2b++;
        prev_start = rd_if.rd_start;
        prev_abort = rd_if.rd_abort;
        prev_fv    = frame_valid;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".buttons"}, buttons, 0);
        chk({tag, ".analog"}, {joy_x, joy_y, c_x, c_y, l_trig, r_trig}, 48'h8080_8080_0000);
        chk({tag, ".pulses"}, {pressed, released, frame_valid}, 0);
        chk({tag, ".connected"}, connected, 0);
        chk({tag, ".rd_start_abort"}, {rd_if.rd_start, rd_if.rd_abort}, 0);
    endtask

    // Leaves the bench on the negedge where rd_start is visible (REQ cycle).
    task automatic wait_start(output bit ok, output int k);
        ok = 1'b0;
        for (k = 0; k < 2 * POLL_DIV + 10; k++) begin
            if (rd_if.rd_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input string p, input vec_t v, output int wk);
        bit ok;
        int k, ab0, s0;
        wait_start(ok, wk);
        chk({p, ".start_seen"}, ok, 1);
        if (!ok) return;
        ab0 = n_abort;
        s0  = n_start;
        if (v.lat < 0) begin
            k = 0;
            while (!rd_if.rd_abort && k < TIMEOUT_CYC + 20) begin
                @(negedge clk);
                k++;
            end
            chk({p, ".abort_latency"}, k, TIMEOUT_CYC + 1);
        end else begin
            repeat (v.lat) @(negedge clk);
            rd_if.rd_done = 1'b1;
            rd_if.rd_err  = v.err;
            rd_if.rd_data = v.data;
            @(negedge clk);
            rd_if.rd_done = 1'b0;
            rd_if.rd_err  = 1'b1;     // unqualified noise must be ignored
            rd_if.rd_data = ~v.data;
        end
        @(negedge clk);
        chk({p, ".buttons"}, buttons, v.e_btn);
        chk({p, ".pressed"}, pressed, v.e_pr);
        chk({p, ".released"}, released, v.e_rl);
        chk({p, ".frame_valid"}, frame_valid, v.e_fv);
        chk({p, ".connected"}, connected, v.e_conn);
        chk({p, ".analog"}, {joy_x, joy_y, c_x, c_y, l_trig, r_trig}, v.e_an);
        chk({p, ".no_extra_start"}, n_start - s0, 0);
        @(negedge clk);
        chk({p, ".pulses_cleared"}, {pressed, released, frame_valid, rd_if.rd_abort}, 0);
        chk({p, ".abort_count"}, n_abort - ab0, (v.lat < 0) ? 1 : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int wk, ab0;
        vec_t lv;

        //           lat err data                    btn     pr      rl      fv   conn an
        vecs[0]  = '{20, 0, 64'h0180_8080_8080_0000, 12'h001, 12'h001, 12'h000, 1, 1, 48'h8080_8080_0000};
        vecs[1]  = '{30, 0, 64'h0180_8080_8080_0000, 12'h001, 12'h000, 12'h000, 1, 1, 48'h8080_8080_0000};
        vecs[2]  = '{15, 0, 64'h02C8_1234_5678_9ABC, 12'h122, 12'h122, 12'h001, 1, 1, 48'h1234_5678_9ABC};
        vecs[3]  = '{25, 0, 64'h1FFF_0011_2233_4455, 12'hFFF, 12'hEDD, 12'h000, 1, 1, 48'h0011_2233_4455};
        vecs[4]  = '{12, 0, 64'h1491_A0B0_C0D0_E0F0, 12'h894, 12'h000, 12'h76B, 1, 1, 48'hA0B0_C0D0_E0F0};
        vecs[5]  = '{ 8, 0, 64'h08A6_0102_0304_0506, 12'h648, 12'h648, 12'h894, 1, 1, 48'h0102_0304_0506};
        vecs[6]  = '{-1, 0, 64'h0,                   12'h648, 12'h000, 12'h000, 0, 1, 48'h0102_0304_0506};
        vecs[7]  = '{10, 1, 64'h0180_8080_8080_0000, 12'h648, 12'h000, 12'h000, 0, 1, 48'h0102_0304_0506};
        vecs[8]  = '{10, 0, 64'h0100_8080_8080_0000, 12'h000, 12'h000, 12'h648, 0, 0, 48'h8080_8080_0000};
        vecs[9]  = '{10, 0, 64'h2180_8080_8080_0000, 12'h000, 12'h000, 12'h000, 0, 0, 48'h8080_8080_0000};
        vecs[10] = '{20, 0, 64'h0180_1234_5678_9ABC, 12'h001, 12'h001, 12'h000, 1, 1, 48'h1234_5678_9ABC};
        vecs[11] = '{-1, 0, 64'h0,                   12'h001, 12'h000, 12'h000, 0, 1, 48'h1234_5678_9ABC};
        vecs[12] = '{-1, 0, 64'h0,                   12'h001, 12'h000, 12'h000, 0, 1, 48'h1234_5678_9ABC};
        vecs[13] = '{-1, 0, 64'h0,                   12'h000, 12'h000, 12'h001, 0, 0, 48'h8080_8080_0000};
        vecs[14] = '{10, 1, 64'h0180_1234_5678_9ABC, 12'h000, 12'h000, 12'h000, 0, 0, 48'h8080_8080_0000};
        vecs[15] = '{40, 0, 64'h0180_1234_5678_9ABC, 12'h001, 12'h001, 12'h000, 1, 1, 48'h1234_5678_9ABC};

        rd_if.rd_done = 1'b0;
        rd_if.rd_err  = 1'b0;
        rd_if.rd_data = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i], wk);
        end

        // Slow reader: ticks during each transaction collapse into one poll
        // that issues as soon as the scheduler is idle again.
        lv = '{250, 0, 64'h0180_1234_5678_9ABC, 12'h001, 12'h000, 12'h000, 1, 1, 48'h1234_5678_9ABC};
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("slow%0d", i), lv, wk);
            if (i > 0) chk($sformatf("slow%0d.immediate_start", i), wk, 0);
        end
        chk("pulse_width", n_b2b, 0);

        // Reset in the middle of WAIT.
        wait_start(ok, wk);
        chk("midrst.start_seen", ok, 1);
        repeat (5) @(negedge clk);
        ab0 = n_abort;
        reset = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_start(ok, wk);
        chk("midrst.first_poll_delay", wk, POLL_DIV + 1);
        chk("midrst.no_abort", n_abort - ab0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gc_poll_scheduler.md
Name: gc_poll_scheduler

Overview:
Sequences the single-wire GameCube reader: issues periodic poll requests, supervises completion with a timeout, validates each 64-bit response and latches a coherent snapshot for game logic. Sits between the `gamecube` reader instance and the game/VGA logic in `top`. It also provides one-cycle press/release pulses and a connected flag with failure debounce.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- POLL_HZ, 120, poll rate. POLL_DIV = CLK_HZ/POLL_HZ cycles per tick.
- TIMEOUT_CYC, 50_000, maximum cycles in WAIT before abort (500 us).
- MAX_FAIL, 3, consecutive failed polls before the scheduler declares disconnect.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-low (0 = reset).
- rd_start, output, 1, one-cycle pulse that starts a reader transaction.
- rd_abort, output, 1, one-cycle pulse that cancels the reader transaction on timeout.
- rd_done, input, 1, one-cycle pulse; transaction finished.
- rd_err, input, 1, qualified by rd_done; a line or protocol error occurred.
- rd_data, input, 64, response. Bit 63 is the first bit received.
- buttons, output, 12, held buttons: [0]A [1]B [2]X [3]Y [4]start [5]L [6]R [7]Z [8]Dup [9]Ddown [10]Dright [11]Dleft.
- joy_x, joy_y, c_x, c_y, l_trig, r_trig, output, 8 each, analog values.
- pressed, output, 12, one-cycle rising-edge pulses per button.
- released, output, 12, one-cycle falling-edge pulses per button.
- frame_valid, output, 1, one-cycle pulse when the snapshot updates.
- connected, output, 1, level flag; controller is responding.

Behaviour:
- Reset values:
  - All pulse outputs 0, buttons 0.
  - joy_x/joy_y/c_x/c_y = 8'h80; l_trig/r_trig = 0.
  - connected 0, fail_cnt 0, tick counter 0, pending 0, state IDLE.
- Tick generation:
  - The divider is free-running and wraps at POLL_DIV-1. On wrap it sets `pending`.
  - A wrap while `pending` is already 1 is dropped; the scheduler never queues more than one poll.
- State IDLE: when pending=1, go to REQ and clear pending.
- State REQ: assert rd_start for exactly one cycle, clear the timeout counter, go to WAIT.
- State WAIT:
  - rd_done=1 → go to UPDATE.
  - Timeout counter reaches TIMEOUT_CYC-1 without rd_done → assert rd_abort for one cycle and record a failure.
  - If rd_done and timeout occur in the same cycle, rd_done wins.
- State UPDATE (one cycle) validates the frame:
  - Valid means rd_err=0, rd_data[63:61]=3'b000 and rd_data[55]=1.
- Valid frame:
  - Map fields: A=bit56, B=57, X=58, Y=59, start=60, Dleft=48, Dright=49, Ddown=50, Dup=51, Z=52, R=53, L=54.
  - Analog fields: joy_x=[47:40], joy_y=[39:32], c_x=[31:24], c_y=[23:16], l_trig=[15:8], r_trig=[7:0].
  - Register all outputs on the cycle after UPDATE, together with frame_valid=1.
  - pressed = new & ~old; released = ~new & old.
  - Set fail_cnt=0 and connected=1.
- Failure (invalid frame or timeout):
  - The snapshot holds its previous value and fail_cnt increments, saturating at MAX_FAIL.
  - On the transition to MAX_FAIL: connected←0 and the snapshot goes to its neutral reset values.
  - released pulses for any buttons that were held; frame_valid stays 0.
- After UPDATE or failure handling, return to IDLE.
- Reset asserted mid-transaction: return to IDLE on the next edge with no rd_abort pulse. The reader shares the same reset.
- Pulse outputs are never asserted for more than one cycle and are 0 in every other cycle.

Decomposition:
- Shared package `gc_pkg` holds:
  - the state enum;
  - button index localparams;
  - bit positions of the rd_data fields;
  - neutral stick value 8'h80.
- One natural sub-module, `gc_edge_detect`: a 12-bit register plus pressed/released pulse generation, with a load enable and a clear-to-neutral input.

Test Plan:
- Reset, then rd_done 20 cycles after rd_start with data 64'h0180_8080_8080_0000 → frame_valid pulse, buttons=12'h001, pressed=12'h001 for one cycle, connected=1.
- Two identical valid frames, then a frame with A released → pressed stays 0 on the second frame; released[0]=1 for one cycle on the third.
- No rd_done for TIMEOUT_CYC cycles → rd_abort pulse one cycle, snapshot unchanged. After 3 consecutive timeouts → connected=0, sticks 8'h80, released pulses for held buttons.
- rd_done with rd_err=1, then with bit 55=0 → both count as failures; a following valid frame resets fail_cnt and connected=1.
- POLL_DIV=100 with response latency 250 cycles → exactly one rd_start per completed transaction, extra ticks dropped, no back-to-back rd_start.
- reset low during WAIT → next cycle state IDLE, all outputs at reset values, no rd_abort.
